// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one floating-point divider
// Grants one requester at a time and sequences the divider's level start/finish handshake.
module div_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   op_a,
  input  logic [32*NREQ-1:0]   op_b,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          result,
  output logic                 busy,
  output logic                 div_start,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_result,
  input  logic                 div_finish
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       result_q, result_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [31:0]       div_a_q, div_a_d;
  logic [31:0]       div_b_q, div_b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     last_q, last_d;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;
  logic              grant_en;

  // Walk downward so the requester nearest after last_q is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    result_d = result_q;
    start_d  = start_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    grant_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) grant_en = 1'b1;
      end
      RUN: begin
        if (div_finish) begin
          result_d       = div_result;
          done_d[gnt_q]  = 1'b1;
          start_d        = 1'b0;
          state_d        = RECOVER;
        end else if (cnt_q == CNT_LAST) begin
          done_d[gnt_q]  = 1'b1;
          err_d          = 1'b1;
          start_d        = 1'b0;
          state_d        = RECOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECOVER: begin
        // A finish still high here belongs to the previous operation.
        if (!div_finish) begin
          if (pick_valid) grant_en = 1'b1;
          else            state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      div_a_d          = op_a[{pick_idx, 5'd0} +: 32];
      div_b_d          = op_b[{pick_idx, 5'd0} +: 32];
      ack_d[pick_idx]  = 1'b1;
      start_d          = 1'b1;
      gnt_d            = pick_idx;
      last_d           = pick_idx;
      cnt_d            = '0;
      state_d          = RUN;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      div_a_q  <= '0;
      div_b_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      last_q   <= IDX_TOP;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign div_start = start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed vector bench for div_arbiter
// Uses a behavioural divider stub with hang and stale-finish modes.
module tb_div_arbiter;

  localparam int NREQ     = 3;
  localparam int MAX_WAIT = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   op_a;
  logic [32*NREQ-1:0]   op_b;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      done;
  logic                 err;
  logic [31:0]          result;
  logic                 busy;
  logic                 div_start;
  logic [31:0]          div_a;
  logic [31:0]          div_b;
  logic [31:0]          div_result;
  logic                 div_finish;

  int errors = 0;
  int checks = 0;

  div_arbiter #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .done(done), .err(err), .result(result), .busy(busy),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_finish(div_finish)
  );

  always #5 clk = ~clk;

  // Divider stub: finish two edges after start, optional hang or 3-cycle stale finish.
  logic       stub_hang  = 1'b0;
  logic       stub_stale = 1'b0;
  logic [1:0] st_cnt     = 2'd0;
  logic [1:0] stale_cnt  = 2'd0;
  logic       fin_r      = 1'b0;

  always @(posedge clk) begin
    if (div_start) begin
      stale_cnt <= 2'd0;
      if (st_cnt != 2'd2) st_cnt <= st_cnt + 2'd1;
      fin_r <= (st_cnt >= 2'd1) && !stub_hang;
    end else begin
      st_cnt <= 2'd0;
      if (fin_r && stub_stale && stale_cnt != 2'd3) begin
        stale_cnt <= stale_cnt + 2'd1;
      end else begin
        fin_r     <= 1'b0;
        stale_cnt <= 2'd0;
      end
    end
  end

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_3F000000: return 32'h40800000;
      64'h40C00000_40000000: return 32'h40400000;
      64'h3F800000_40800000: return 32'h3E800000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  assign div_finish = fin_r;
  assign div_result = fin_r ? quot(div_a, div_b) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int idx;
    idx = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < NREQ; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic wait_ack(output int idx, output int cyc);
    idx = -1;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        idx = onehot_idx(ack);
        return;
      end
    end
  endtask

  task automatic wait_done(output int idx, output int cyc);
    idx = -1;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (done != '0) begin
        idx = onehot_idx(done);
        return;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    op_a[32*r +: 32] = a;
    op_b[32*r +: 32] = b;
  endtask

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic        hang;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc;

    vt[0] = '{0, 32'h40000000, 32'h3F000000, 1'b0, 32'h40800000, 1'b0, 3};
    vt[1] = '{2, 32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 3};
    vt[2] = '{1, 32'h40000000, 32'h3F000000, 1'b1, 32'h40400000, 1'b1, MAX_WAIT};
    vt[3] = '{1, 32'h3F800000, 32'h40800000, 1'b0, 32'h3E800000, 1'b0, 3};

    reset = 1'b1;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    check("rst ack",       {29'd0, ack},  32'd0);
    check("rst done",      {29'd0, done}, 32'd0);
    check("rst err",       {31'd0, err},  32'd0);
    check("rst busy",      {31'd0, busy}, 32'd0);
    check("rst div_start", {31'd0, div_start}, 32'd0);
    check("rst result",    result, 32'd0);
    check("rst div_a",     div_a,  32'd0);
    check("rst div_b",     div_b,  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two simultaneous requests straight out of reset.
    set_ops(0, 32'h40C00000, 32'h40000000);
    set_ops(1, 32'h3F800000, 32'h40800000);
    req = 3'b011;
    wait_ack(idx, cyc);
    check("sim first ack", idx, 0);
    req = 3'b010;
    wait_done(idx, cyc);
    check("sim done0 idx", idx, 0);
    check("sim done0 lat", cyc, 3);
    check("sim result0", result, 32'h40400000);
    wait_ack(idx, cyc);
    check("sim second ack", idx, 1);
    check("sim done-ack gap", cyc, 2);
    req = 3'b000;
    wait_done(idx, cyc);
    check("sim done1 idx", idx, 1);
    check("sim result1", result, 32'h3E800000);
    wait_idle("sim idle");

    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      stub_hang = vt[v].hang;
      set_ops(vt[v].rq, vt[v].a, vt[v].b);
      req = '0;
      req[vt[v].rq] = 1'b1;
      wait_ack(idx, cyc);
      check($sformatf("vec%0d ack", v), idx, vt[v].rq);
      check($sformatf("vec%0d div_start", v), {31'd0, div_start}, 32'd1);
      check($sformatf("vec%0d div_a", v), div_a, vt[v].a);
      check($sformatf("vec%0d div_b", v), div_b, vt[v].b);
      req = '0;
      wait_done(idx, cyc);
      check($sformatf("vec%0d done", v), idx, vt[v].rq);
      check($sformatf("vec%0d latency", v), cyc, vt[v].exp_lat);
      check($sformatf("vec%0d err", v), {31'd0, err}, {31'd0, vt[v].exp_err});
      check($sformatf("vec%0d result", v), result, vt[v].exp_res);
      wait_idle($sformatf("vec%0d idle", v));
      stub_hang = 1'b0;
    end

    // Round-robin with every request held high.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < NREQ; r++) set_ops(r, 32'h40000000, 32'h3F000000);
    req = 3'b111;
    for (int i = 0; i < 9; i++) begin
      wait_ack(idx, cyc);
      check($sformatf("rr grant %0d", i), idx, i % NREQ);
      if (i == 8) req = '0;
    end
    wait_done(idx, cyc);
    check("rr last result", result, 32'h40800000);
    wait_idle("rr idle");

    // Stale finish holds off the next grant until finish is seen low.
    stub_stale = 1'b1;
    set_ops(0, 32'h40000000, 32'h3F000000);
    set_ops(1, 32'h3F800000, 32'h40800000);
    req = 3'b011;
    wait_ack(idx, cyc);
    check("stale ack0", idx, 0);
    req = 3'b010;
    wait_done(idx, cyc);
    check("stale result0", result, 32'h40800000);
    wait_ack(idx, cyc);
    check("stale ack1", idx, 1);
    check("stale gap", cyc, 5);
    req = '0;
    wait_done(idx, cyc);
    check("stale result1", result, 32'h3E800000);
    wait_idle("stale idle");
    stub_stale = 1'b0;

    // Reset one cycle into RUN.
    req = 3'b001;
    wait_ack(idx, cyc);
    check("rrun ack", idx, 0);
    req = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rrun div_start", {31'd0, div_start}, 32'd0);
    check("rrun busy", {31'd0, busy}, 32'd0);
    check("rrun done", {29'd0, done}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rrun held done", {29'd0, done}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    req = 3'b001;
    wait_ack(idx, cyc);
    check("post ack", idx, 0);
    req = '0;
    wait_done(idx, cyc);
    check("post done", idx, 0);
    check("post latency", cyc, 3);
    check("post err", {31'd0, err}, 32'd0);
    check("post result", result, 32'h40800000);
    wait_idle("post idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one floating-point divider unit between NREQ requesters. In the conjugate-gradient datapath these are the alpha (rTr/pAp) and beta (rTr_new/rTr_old) calculators.
- Round-robin arbitration picks one requester. The block latches that requester's operands and sequences the divider's level-sensitive start/finish_flag handshake.
- It returns the 32-bit quotient with a per-requester done pulse.
- It sits between the CG control FSM and the single division instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_WAIT, 64, cycles to wait for div_finish before aborting the operation.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- op_a  input  32*NREQ  dividend per requester, IEEE-754 single; requester i uses bits [32i+31:32i].
- op_b  input  32*NREQ  divisor per requester, same packing.
- ack  output  NREQ  one-cycle pulse: the request is granted and its operands are latched.
- done  output  NREQ  one-cycle pulse: result is valid for this requester.
- err  output  1  one-cycle pulse, coincident with done, when the operation timed out.
- result  output  32  registered quotient; holds its value until the next successful completion.
- busy  output  1  high in any state other than IDLE.
- div_start  output  1  start level to the divider.
- div_a  output  32  dividend to the divider.
- div_b  output  32  divisor to the divider.
- div_result  input  32  quotient from the divider.
- div_finish  input  1  finish_flag from the divider.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - ack, done, err, div_start, busy = 0.
  - result, div_a, div_b = 0.
  - wait counter = 0.
  - rr pointer set so requester 0 has highest priority.
- Divider contract:
  - Holding div_start high gives div_finish=1 after two clock edges; div_finish stays 1 while div_start stays high.
  - Dropping div_start clears div_finish on the next edge.
  - div_result is valid whenever div_finish=1.
- States: IDLE, RUN, RECOVER. All outputs are registered.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from (last_grant+1) mod NREQ.
  - On the grant edge: latch op_a/op_b slices into div_a/div_b, pulse ack[i], set div_start=1, record the grant index, clear the wait counter, go to RUN.
  - If no req bit is set, stay in IDLE.
- RUN:
  - If div_finish=1: capture div_result into result, pulse done[g], drop div_start, go to RECOVER.
  - Else if counter==MAX_WAIT-1: pulse done[g] and err, leave result unchanged, drop div_start, go to RECOVER.
  - Else increment the counter.
- RECOVER:
  - div_start stays 0 until div_finish=0 is sampled. This stops a stale finish from satisfying the next operation.
  - When div_finish=0: grant directly (same rules as IDLE) if any req is pending, otherwise go to IDLE.
- Timing with a compliant divider:
  - ack at edge E0, done at E3, next ack at E5 at the earliest.
  - The done-to-next-ack gap is 2 cycles.
- Requester rules:
  - Hold req and operands stable until ack is seen.
  - Deassert req in the cycle after ack.
  - req still high after done counts as a new request.
  - A req dropped before ack is never granted; no partial state is kept.
- Fairness:
  - last_grant is updated on every grant.
  - With all req bits continuously high, grants cycle 0,1,..,NREQ-1,0.
- Simultaneous events:
  - ack and done never coincide for the same requester.
  - A grant from RECOVER may pulse ack[j] while done[g] pulsed 2 cycles earlier; each is one cycle wide.
- Mid-operation events:
  - A req change during RUN/RECOVER has no effect on the active operation.
  - Reset during RUN drops div_start immediately (asynchronously); no done is generated.
- Arithmetic: none in this block; operands and result pass through bit-exact.

Test Plan:
- Single request: req=01, op_a[0]=0x40000000 (2.0), op_b[0]=0x3F000000 (0.5) -> ack=01 at E0, div_start high E0–E3, done=01 at E3, result=0x40800000 (4.0), err=0.
- Simultaneous requests after reset: req=11; requester 0 computes 6.0/2.0 (0x40C00000/0x40000000), requester 1 computes 1.0/4.0 (0x3F800000/0x40800000).
  - Requester 0 is granted first, done with result=0x40400000.
  - Requester 1 ack comes ≥2 cycles after done[0]; its result=0x3E800000.
- Fairness: NREQ=3, all req held high for 9 grants -> ack sequence 0,1,2,0,1,2,0,1,2.
- Timeout: divider stub keeps div_finish=0 -> done[g] and err pulse exactly MAX_WAIT cycles after ack; result keeps its previous value; state returns to IDLE.
- Stale finish: stub holds div_finish=1 for 3 extra cycles after div_start drops -> no ack issued until div_finish=0 is sampled.
- Reset mid-RUN: assert reset one cycle after ack -> div_start, busy, done go 0 without waiting for a clock edge. After release, a new req=01 completes normally.
